// File: rtl/mips_pkg.sv
// Shared MIPS opcodes, forwarding-select encodings and instruction-field decode
// helpers used by the ID/EX stage and its forwarding-select sub-block.
package mips_pkg;

    localparam logic [5:0] ALUop   = 6'd0;
    localparam logic [5:0] Jop     = 6'd2;
    localparam logic [5:0] JALop   = 6'd3;
    localparam logic [5:0] ADD_IMM = 6'd8;
    localparam logic [5:0] LW      = 6'd35;
    localparam logic [5:0] SW      = 6'd43;

    localparam logic [1:0] FWD_ID  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    typedef struct packed {
        logic [5:0] op;
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] rd;
        logic [4:0] shamt;
        logic [5:0] funct;
    } ir_fields_t;

    function automatic ir_fields_t split_ir(input logic [31:0] ir);
        return ir_fields_t'(ir);
    endfunction

    // Register written by the instruction; 0 means no architectural write.
    function automatic logic [4:0] dest_reg(input logic [31:0] ir);
        ir_fields_t f;
        f = split_ir(ir);
        case (f.op)
            ALUop:       return f.rd;
            LW, ADD_IMM: return f.rt;
            default:     return 5'd0;
        endcase
    endfunction

    function automatic logic uses_rs(input logic [31:0] ir);
        ir_fields_t f;
        f = split_ir(ir);
        return (f.op == ALUop) || (f.op == LW) || (f.op == SW) || (f.op == ADD_IMM);
    endfunction

    // Only register-register ALU ops feed rt into the ALU; SW rt is store data.
    function automatic logic uses_rt_alu(input logic [31:0] ir);
        ir_fields_t f;
        f = split_ir(ir);
        return f.op == ALUop;
    endfunction

    function automatic logic is_load(input logic [31:0] ir);
        ir_fields_t f;
        f = split_ir(ir);
        return f.op == LW;
    endfunction

endpackage

// File: rtl/fwd_sel.sv
// Forwarding select for one source register, evaluated against the instructions
// that will sit in EX/MEM and MEM/WB when the consumer reaches EX.
module fwd_sel
    import mips_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic [4:0]    r,
    input  logic [DW-1:0] idex_ir,
    input  logic          idex_valid,
    input  logic [DW-1:0] exmem_ir,
    output logic [1:0]    sel
);

    logic [4:0] idex_dest;
    logic [4:0] exmem_dest;

    assign idex_dest  = dest_reg(idex_ir[31:0]);
    assign exmem_dest = dest_reg(exmem_ir[31:0]);

    // The nearer producer (current ID/EX) holds the newest value, so it wins.
    always_comb begin
        sel = FWD_ID;
        if (r != 5'd0) begin
            if (idex_valid && (idex_dest == r)) begin
                sel = FWD_MEM;
            end else if (exmem_dest == r) begin
                sel = FWD_WB;
            end
        end
    end

endmodule

// File: rtl/idex_fwd_stage.sv
// ID/EX pipeline register with registered ALU forwarding selects, load-use
// hazard detection (stall + bubble) and a saturating stall-cycle counter.
module idex_fwd_stage
    import mips_pkg::*;
#(
    parameter int DW  = 32,
    parameter int SCW = 16
) (
    input  logic           clock,
    input  logic           reset_n,
    input  logic           id_valid,
    input  logic [DW-1:0]  id_ir,
    input  logic [DW-1:0]  id_a,
    input  logic [DW-1:0]  id_b,
    input  logic [DW-1:0]  id_pc,
    input  logic           flush,
    input  logic [DW-1:0]  exmem_ir,
    output logic [DW-1:0]  idex_ir,
    output logic [DW-1:0]  idex_a,
    output logic [DW-1:0]  idex_b,
    output logic [DW-1:0]  idex_pc,
    output logic           idex_valid,
    output logic [1:0]     fa,
    output logic [1:0]     fb,
    output logic           stall,
    output logic [SCW-1:0] stall_count
);

    ir_fields_t id_f;
    logic [4:0] load_dest;
    logic       idex_is_load;
    logic       rs_conflict;
    logic       rt_conflict;
    logic       hazard;
    logic       bubble;
    logic [1:0] sel_rs;
    logic [1:0] sel_rt;
    logic [1:0] fa_next;
    logic [1:0] fb_next;

    assign id_f         = split_ir(id_ir[31:0]);
    assign load_dest    = dest_reg(idex_ir[31:0]);
    assign idex_is_load = idex_valid && is_load(idex_ir[31:0]);

    assign rs_conflict = uses_rs(id_ir[31:0]) && (id_f.rs == load_dest);
    assign rt_conflict = uses_rt_alu(id_ir[31:0]) && (id_f.rt == load_dest);

    // Handshake: id_valid qualifies the decode slot; stall is the same-cycle
    // back-pressure telling IF/ID to hold, and idex_valid qualifies the EX slot.
    // A load's data is not ready for a consumer directly behind it, so the
    // consumer is held one cycle and then picks the value up from MEM/WB.
    assign hazard = reset_n && idex_is_load && id_valid && (load_dest != 5'd0)
                    && (rs_conflict || rt_conflict);
    assign stall  = hazard;
    assign bubble = hazard || flush;

    fwd_sel #(.DW(DW)) u_fwd_rs (
        .r          (id_f.rs),
        .idex_ir    (idex_ir),
        .idex_valid (idex_valid),
        .exmem_ir   (exmem_ir),
        .sel        (sel_rs)
    );

    fwd_sel #(.DW(DW)) u_fwd_rt (
        .r          (id_f.rt),
        .idex_ir    (idex_ir),
        .idex_valid (idex_valid),
        .exmem_ir   (exmem_ir),
        .sel        (sel_rt)
    );

    assign fa_next = uses_rs(id_ir[31:0])     ? sel_rs : FWD_ID;
    assign fb_next = uses_rt_alu(id_ir[31:0]) ? sel_rt : FWD_ID;

    // A bubble is an all-zero IR (sll r0), which has no destination.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            idex_ir    <= '0;
            idex_a     <= '0;
            idex_b     <= '0;
            idex_pc    <= '0;
            idex_valid <= 1'b0;
            fa         <= FWD_ID;
            fb         <= FWD_ID;
        end else if (bubble) begin
            idex_ir    <= '0;
            idex_a     <= '0;
            idex_b     <= '0;
            idex_pc    <= '0;
            idex_valid <= 1'b0;
            fa         <= FWD_ID;
            fb         <= FWD_ID;
        end else begin
            idex_ir    <= id_ir;
            idex_a     <= id_a;
            idex_b     <= id_b;
            idex_pc    <= id_pc;
            idex_valid <= id_valid;
            fa         <= fa_next;
            fb         <= fb_next;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            stall_count <= '0;
        end else if (hazard && (stall_count != {SCW{1'b1}})) begin
            stall_count <= stall_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_idex_fwd_stage.sv
// Scoreboard bench for idex_fwd_stage: a reference model pushes the expected
// ID/EX contents per driven cycle, popped and compared after the clock edge.
module tb_idex_fwd_stage;

  localparam int DW  = 32;
  localparam int SCW = 8;  // narrow counter keeps the saturation sweep short
  localparam int EW  = 1 + 4 * DW + 1 + 2 + 2 + SCW;

  logic           clock = 1'b0;
  logic           reset_n = 1'b0;
  logic           id_valid = 1'b0;
  logic [DW-1:0]  id_ir = '0;
  logic [DW-1:0]  id_a = '0;
  logic [DW-1:0]  id_b = '0;
  logic [DW-1:0]  id_pc = '0;
  logic           flush = 1'b0;
  logic [DW-1:0]  exmem_ir = '0;
  logic [DW-1:0]  idex_ir;
  logic [DW-1:0]  idex_a;
  logic [DW-1:0]  idex_b;
  logic [DW-1:0]  idex_pc;
  logic           idex_valid;
  logic [1:0]     fa;
  logic [1:0]     fb;
  logic           stall;
  logic [SCW-1:0] stall_count;

  int n_checks = 0;
  int n_errors = 0;

  logic [EW-1:0] exp_q[$];

  logic [DW-1:0]  m_ir;
  logic           m_valid;
  logic [SCW-1:0] m_cnt;

  // ---------------- clock ----------------
  always #5 clock = ~clock;

  idex_fwd_stage #(.DW(DW), .SCW(SCW)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .id_valid    (id_valid),
    .id_ir       (id_ir),
    .id_a        (id_a),
    .id_b        (id_b),
    .id_pc       (id_pc),
    .flush       (flush),
    .exmem_ir    (exmem_ir),
    .idex_ir     (idex_ir),
    .idex_a      (idex_a),
    .idex_b      (idex_b),
    .idex_pc     (idex_pc),
    .idex_valid  (idex_valid),
    .fa          (fa),
    .fb          (fb),
    .stall       (stall),
    .stall_count (stall_count)
  );

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- encoders and reference model ----------------
  function automatic logic [31:0] r_op(input logic [5:0] funct, input logic [4:0] rd,
                                       input logic [4:0] rs, input logic [4:0] rt);
    return {6'd0, rs, rt, rd, 5'd0, funct};
  endfunction

  function automatic logic [31:0] i_op(input logic [5:0] op, input logic [4:0] rs,
                                       input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [4:0] ref_dest(input logic [31:0] ir);
    if (ir[31:26] == 6'd0) return ir[15:11];
    if (ir[31:26] == 6'd35 || ir[31:26] == 6'd8) return ir[20:16];
    return 5'd0;
  endfunction

  function automatic logic ref_uses_rs(input logic [31:0] ir);
    return ir[31:26] == 6'd0 || ir[31:26] == 6'd35 || ir[31:26] == 6'd43 || ir[31:26] == 6'd8;
  endfunction

  function automatic logic [1:0] ref_sel(input logic [4:0] r);
    if (r == 5'd0) return 2'b00;
    if (m_valid && ref_dest(m_ir) == r) return 2'b10;
    if (ref_dest(exmem_ir) == r) return 2'b01;
    return 2'b00;
  endfunction

  // ---------------- driver ----------------
  task automatic step(input logic v, input logic [DW-1:0] ir, input logic [DW-1:0] a,
                      input logic [DW-1:0] b, input logic [DW-1:0] pc, input logic fl);
    logic           haz, bub, ev, gb;
    logic [4:0]     d;
    logic [1:0]     efa, efb;
    logic [DW-1:0]  eir, ea, eb, epc;
    logic [SCW-1:0] ec;
    logic [EW-1:0]  e;
    id_valid = v; id_ir = ir; id_a = a; id_b = b; id_pc = pc; flush = fl;
    #1;
    d   = ref_dest(m_ir);
    haz = m_valid && (m_ir[31:26] == 6'd35) && v && (d != 5'd0) &&
          ((ref_uses_rs(ir) && ir[25:21] == d) || (ir[31:26] == 6'd0 && ir[20:16] == d));
    check("stall", 64'(stall), 64'(haz));
    bub = haz || fl;
    efa = ref_uses_rs(ir) ? ref_sel(ir[25:21]) : 2'b00;
    efb = (ir[31:26] == 6'd0) ? ref_sel(ir[20:16]) : 2'b00;
    if (bub) begin
      eir = '0; ea = '0; eb = '0; epc = '0; ev = 1'b0; efa = 2'b00; efb = 2'b00;
    end else begin
      eir = ir; ea = a; eb = b; epc = pc; ev = v;
    end
    ec = (haz && m_cnt != {SCW{1'b1}}) ? m_cnt + 1'b1 : m_cnt;
    exp_q.push_back({bub, eir, ea, eb, epc, ev, efa, efb, ec});
    @(posedge clock);
    #1;
    e = exp_q.pop_front();
    {gb, eir, ea, eb, epc, ev, efa, efb, ec} = e;
    check("idex_ir", 64'(idex_ir), 64'(eir));
    check("idex_valid", 64'(idex_valid), 64'(ev));
    check("fa", 64'(fa), 64'(efa));
    check("fb", 64'(fb), 64'(efb));
    check("stall_count", 64'(stall_count), 64'(ec));
    if (!gb) begin
      check("idex_a", 64'(idex_a), 64'(ea));
      check("idex_b", 64'(idex_b), 64'(eb));
      check("idex_pc", 64'(idex_pc), 64'(epc));
    end
    exmem_ir = m_ir;
    m_ir = eir; m_valid = ev; m_cnt = ec;
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    #1;
    check("rst_stall", 64'(stall), 64'd0);
    check("rst_ir", 64'(idex_ir), 64'd0);
    check("rst_a", 64'(idex_a), 64'd0);
    check("rst_b", 64'(idex_b), 64'd0);
    check("rst_pc", 64'(idex_pc), 64'd0);
    check("rst_valid", 64'(idex_valid), 64'd0);
    check("rst_fa", 64'(fa), 64'd0);
    check("rst_fb", 64'(fb), 64'd0);
    check("rst_count", 64'(stall_count), 64'd0);
    id_valid = 1'b0; id_ir = '0; id_a = '0; id_b = '0; id_pc = '0; flush = 1'b0;
    exmem_ir = '0;
    m_ir = '0; m_valid = 1'b0; m_cnt = '0;
    exp_q.delete();
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] lw_r2, add_use;
    lw_r2   = i_op(6'd35, 5'd1, 5'd2, 16'd0);
    add_use = r_op(6'h20, 5'd4, 5'd2, 5'd2);
    #3;
    apply_reset();

    // back-to-back ALU forwarding
    step(1, r_op(6'h20, 5'd3, 5'd1, 5'd2), 32'h11, 32'h22, 32'h100, 0);
    step(1, r_op(6'h22, 5'd5, 5'd3, 5'd4), 32'h33, 32'h44, 32'h104, 0);
    check("b2b_fa_mem", 64'(fa), 64'(2'b10));
    check("b2b_fb_none", 64'(fb), 64'(2'b00));
    step(1, r_op(6'h24, 5'd5, 5'd4, 5'd3), 32'h55, 32'h66, 32'h108, 0);
    check("b2b_fb_wb", 64'(fb), 64'(2'b01));

    // load-use: one stall cycle, then forward from MEM/WB
    apply_reset();
    step(1, lw_r2, 32'h1, 32'h2, 32'h200, 0);
    step(1, add_use, 32'h3, 32'h4, 32'h204, 0);
    check("lu_bubble_valid", 64'(idex_valid), 64'd0);
    check("lu_bubble_ir", 64'(idex_ir), 64'd0);
    step(1, add_use, 32'h3, 32'h4, 32'h204, 0);
    check("lu_fa_wb", 64'(fa), 64'(2'b01));
    check("lu_fb_wb", 64'(fb), 64'(2'b01));
    check("lu_count", 64'(stall_count), 64'd1);

    // async reset while a stall is being asserted
    step(1, lw_r2, 32'h1, 32'h2, 32'h300, 0);
    id_valid = 1'b1; id_ir = add_use;
    #1;
    check("pre_rst_stall", 64'(stall), 64'd1);
    apply_reset();

    // store after load: store data does not stall
    step(1, lw_r2, 32'h1, 32'h2, 32'h400, 0);
    step(1, i_op(6'd43, 5'd3, 5'd2, 16'd4), 32'h7, 32'h8, 32'h404, 0);
    check("sw_valid", 64'(idex_valid), 64'd1);
    check("sw_fb", 64'(fb), 64'(2'b00));

    // r0 never forwards
    step(1, r_op(6'h20, 5'd0, 5'd1, 5'd1), 32'h9, 32'h9, 32'h408, 0);
    step(1, r_op(6'h20, 5'd5, 5'd0, 5'd0), 32'h0, 32'h0, 32'h40c, 0);
    check("r0_fa", 64'(fa), 64'(2'b00));
    check("r0_fb", 64'(fb), 64'(2'b00));

    // flush together with a hazard
    step(1, lw_r2, 32'h1, 32'h2, 32'h500, 0);
    step(1, add_use, 32'h3, 32'h4, 32'h504, 1);
    check("flush_haz_valid", 64'(idex_valid), 64'd0);

    // randomized mix over a small register set
    for (int i = 0; i < 400; i++) begin
      logic [5:0]  op;
      logic [31:0] ir;
      case ($urandom_range(0, 5))
        0, 1:    op = 6'd0;
        2:       op = 6'd35;
        3:       op = 6'd43;
        4:       op = 6'd8;
        default: op = ($urandom_range(0, 1) == 0) ? 6'd2 : 6'd3;
      endcase
      ir = {op, 5'($urandom_range(0, 4)), 5'($urandom_range(0, 4)),
            5'($urandom_range(0, 4)), 5'd0, 6'($urandom_range(0, 63))};
      step(($urandom_range(0, 9) != 0), ir, $urandom, $urandom, $urandom,
           ($urandom_range(0, 9) == 0));
    end

    // counter saturation
    apply_reset();
    for (int i = 0; i < (1 << SCW) + 3; i++) begin
      step(1, lw_r2, 32'h1, 32'h2, 32'h600, 0);
      step(1, add_use, 32'h3, 32'h4, 32'h604, 0);
    end
    check("sat_count", 64'(stall_count), 64'({SCW{1'b1}}));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
